alu_md_unit: RTL

ALU_MD_UNIT -- requirements
Module: alu_md_unit

---
 rtl/alu_md_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_md_unit.sv
// alu_md_unit: single-cycle ALU with iterative multu (and optional divu) writing HI/LO.
// Define ALU_MD_DIV_EN to build the restoring divider and the DIV state.
module alu_md_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MD_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_MUL  = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic             is_mul_c;
  logic             is_div_c;
  logic             last_iter_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ill_c;
  logic [WIDTH:0]   mul_sum_c;

  assign accept_c    = in_valid && in_ready_q;
  assign is_mul_c    = accept_c && (alu_op == 2'b10) && (funct == F_MULTU);
  assign last_iter_c = (cnt_q == SHW'(WIDTH - 1));
  // One shift-add step: conditionally add the multiplicand into the upper half.
  assign mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : {(WIDTH + 1){1'b0}});

`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0] div_shift_c;
  logic [WIDTH:0] div_diff_c;
  assign is_div_c    = accept_c && (alu_op == 2'b10) && (funct == F_DIVU);
  // Restoring step: borrow in the top bit means the trial subtract failed.
  assign div_shift_c = {hi_q, lo_q[WIDTH-1]};
  assign div_diff_c  = div_shift_c - {1'b0, opr_q};
`else
  assign is_div_c    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul_c) begin
          state_d = S_MUL;
`ifdef ALU_MD_DIV_EN
        end else if (is_div_c) begin
          state_d = S_DIV;
`endif
        end
      end
      S_MUL: if (last_iter_c) state_d = S_IDLE;
`ifdef ALU_MD_DIV_EN
      S_DIV: if (last_iter_c) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle operation decode
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (alu_op)
      2'b00: alu_res_c = op_a + op_b;
      2'b01: alu_res_c = op_a - op_b;
      2'b11: alu_res_c = op_a | op_b;
      default: begin
        case (funct)
          F_ADD:   alu_res_c = op_a + op_b;
          F_SUB:   alu_res_c = op_a - op_b;
          F_AND:   alu_res_c = op_a & op_b;
          F_OR:    alu_res_c = op_a | op_b;
          F_SLL:   alu_res_c = op_b << shamt;
          F_SLT:   alu_res_c = WIDTH'($signed(op_a) < $signed(op_b));
          F_MFHI:  alu_res_c = hi_q;
          F_MFLO:  alu_res_c = lo_q;
          F_MULTU: alu_res_c = '0;
`ifdef ALU_MD_DIV_EN
          F_DIVU:  alu_res_c = '0;
`endif
          default: alu_ill_c = 1'b1;
        endcase
      end
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opr_d       = opr_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (is_mul_c) begin
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = op_b;
          opr_d = op_a;
        end else if (is_div_c) begin
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = op_a;
          opr_d = op_b;
        end else if (accept_c) begin
          result_d    = alu_res_c;
          zero_d      = (alu_res_c == '0);
          illegal_d   = alu_ill_c;
          out_valid_d = 1'b1;
        end
      end
      S_MUL: begin
        {hi_d, lo_d} = {mul_sum_c, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q + SHW'(1);
      end
`ifdef ALU_MD_DIV_EN
      S_DIV: begin
        hi_d  = div_diff_c[WIDTH] ? div_shift_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], ~div_diff_c[WIDTH]};
        cnt_d = cnt_q + SHW'(1);
      end
`endif
      default: cnt_d = '0;
    endcase
    if (state_q != S_IDLE && last_iter_c) begin
      cnt_d       = '0;
      result_d    = lo_d;
      zero_d      = (lo_d == '0);
      illegal_d   = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opr_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opr_q       <= opr_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

endmodule
